// File: rtl/goertzel_log_serializer_pkg.sv
// Shared defaults and FSM encoding for the goertzel log2 serializer.
package goertzel_log_serializer_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_FREQS  = 10;
  localparam int DEF_FRAC_BITS  = 3;
  localparam int LOG_INT_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_e;
endpackage

// File: rtl/goertzel_log_serializer_if.sv
// Log-code stream towards the mel/DCT stage (valid/ready).
interface goertzel_log_serializer_if #(
  parameter int LOG_W = 8,
  parameter int IDX_W = 4
) ();
  logic [LOG_W-1:0] log_out;
  logic [IDX_W-1:0] log_bin;
  logic             log_valid;
  logic             log_last;
  logic             log_ready;

  modport master (output log_out, log_bin, log_valid, log_last, input log_ready);
  modport slave  (input log_out, log_bin, log_valid, log_last, output log_ready);
endinterface

// File: rtl/goertzel_log_serializer_log2_approx.sv
// Combinational log2 approximation: leading-one position plus the bits just below it.
module log2_approx
  import goertzel_log_serializer_pkg::*;
#(
  parameter int MAG_W     = 18,
  parameter int FRAC_BITS = 3,
  localparam int LOG_W    = LOG_INT_W + FRAC_BITS
) (
  input  logic [MAG_W-1:0] i_mag,
  output logic [LOG_W-1:0] o_code,
  output logic             o_neg
);
  logic [MAG_W-2:0]     w_u;
  logic [MAG_W-2:0]     w_norm;
  logic [LOG_INT_W-1:0] w_p;
  logic [LOG_INT_W-1:0] w_sh;
  logic [FRAC_BITS-1:0] w_frac;
  logic                 w_pos;

  always_comb begin
    w_u = i_mag[MAG_W-2:0];
    w_p = '0;
    // ascending scan: the highest set bit is written last and wins
    for (int i = 0; i < MAG_W-1; i++) begin
      if (w_u[i]) w_p = LOG_INT_W'(i);
    end
    w_pos  = (|w_u) & ~i_mag[MAG_W-1];
    w_sh   = LOG_INT_W'(MAG_W-2) - w_p;
    w_norm = w_u << w_sh;
    w_frac = w_norm[MAG_W-3 -: FRAC_BITS];
    o_code = w_pos ? {w_p, w_frac} : '0;
    o_neg  = i_mag[MAG_W-1];
  end
endmodule

// File: rtl/goertzel_log_serializer.sv
// Snapshots a goertzel magnitude frame and streams one log2 code per bin over valid/ready.
module goertzel_log_serializer
  import goertzel_log_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_FREQS  = DEF_NUM_FREQS,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  localparam int MAG_W     = DATA_WIDTH + 2,
  localparam int LOG_W     = LOG_INT_W + FRAC_BITS,
  localparam int IDX_W     = $clog2(NUM_FREQS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_FREQS*MAG_W-1:0] i_mag_in,
  input  logic                       i_mag_valid,
  input  logic                       i_ovf_clr,
  output logic                       o_overrun,
  output logic                       o_neg_seen,
  goertzel_log_serializer_if.master  log_if
);
  state_e                             r_state, w_next;
  logic [NUM_FREQS-1:0][MAG_W-1:0]    r_bank;
  logic [IDX_W-1:0]                   r_idx;
  logic [LOG_W-1:0]                   r_log_out;
  logic [IDX_W-1:0]                   r_log_bin;
  logic                               r_log_last, r_log_valid;
  logic                               r_overrun, r_neg_seen;

  logic [LOG_W-1:0] w_code;
  logic             w_neg, w_hs, w_last, w_accept, w_convert;

  log2_approx #(.MAG_W(MAG_W), .FRAC_BITS(FRAC_BITS)) u_log2 (
    .i_mag  (r_bank[r_idx]),
    .o_code (w_code),
    .o_neg  (w_neg)
  );

  assign w_convert = (r_state == ST_CONVERT);
  assign w_hs      = r_log_valid & log_if.log_ready;
  assign w_last    = (r_idx == IDX_W'(NUM_FREQS-1));
  // a frame arriving on the final handshake is taken without a gap
  assign w_accept  = i_mag_valid & ((r_state == ST_IDLE) | (w_hs & r_log_last));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (i_mag_valid) w_next = ST_CONVERT;
      ST_CONVERT: w_next = ST_OUTPUT;
      ST_OUTPUT:  if (w_hs) w_next = (r_log_last && !i_mag_valid) ? ST_IDLE : ST_CONVERT;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= '0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_bank <= i_mag_in;
      r_idx  <= '0;
    end else if (w_hs && !r_log_last) begin
      r_idx  <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log_out   <= '0;
      r_log_bin   <= '0;
      r_log_last  <= 1'b0;
      r_log_valid <= 1'b0;
    end else if (w_convert) begin
      r_log_out   <= w_code;
      r_log_bin   <= r_idx;
      r_log_last  <= w_last;
      r_log_valid <= 1'b1;
    end else if (w_hs) begin
      r_log_valid <= 1'b0;
    end
  end

  // sticky flags: a set event in the same cycle as a clear takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= 1'b0;
      r_neg_seen <= 1'b0;
    end else begin
      r_overrun  <= (r_overrun  & ~i_ovf_clr) | (i_mag_valid & ~w_accept);
      r_neg_seen <= (r_neg_seen & ~i_ovf_clr) | (w_convert & w_neg);
    end
  end

  assign log_if.log_out   = r_log_out;
  assign log_if.log_bin   = r_log_bin;
  assign log_if.log_last  = r_log_last;
  assign log_if.log_valid = r_log_valid;
  assign o_overrun        = r_overrun;
  assign o_neg_seen       = r_neg_seen;
endmodule

// File: tb/tb_goertzel_log_serializer.sv
// Scoreboarded bench for goertzel_log_serializer (DATA_WIDTH=16, NUM_FREQS=10, FRAC_BITS=3).
module tb_goertzel_log_serializer;
  localparam int NF = 10;
  localparam int MW = 18;

  typedef logic [NF-1:0][MW-1:0] bins_t;
  typedef struct packed {
    logic [7:0] code;
    logic [3:0] bin;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  bins_t         mag_in = '0;
  logic          mag_valid = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          overrun, neg_seen;
  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;

  goertzel_log_serializer_if #(.LOG_W(8), .IDX_W(4)) lif ();

  goertzel_log_serializer #(.DATA_WIDTH(16), .NUM_FREQS(NF), .FRAC_BITS(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mag_in    (mag_in),
    .i_mag_valid (mag_valid),
    .i_ovf_clr   (ovf_clr),
    .o_overrun   (overrun),
    .o_neg_seen  (neg_seen),
    .log_if      (lif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_code(input logic signed [MW-1:0] x);
    int p;
    logic [2:0] f;
    if (x <= 0) return 8'h00;
    p = 0;
    for (int b = MW-2; b >= 0; b--) if (x[b]) begin p = b; break; end
    for (int j = 0; j < 3; j++) f[2-j] = (p-1-j >= 0) ? x[p-1-j] : 1'b0;
    return {5'(p), f};
  endfunction

  function automatic void push_model(input bins_t b);
    for (int i = 0; i < NF; i++) sb.push_back('{ref_code(b[i]), 4'(i), (i == NF-1)});
  endfunction

  function automatic bins_t rand_bins();
    bins_t b;
    for (int i = 0; i < NF; i++) b[i] = 18'($urandom_range(0, 131071) >> $urandom_range(0, 16));
    return b;
  endfunction

  // scoreboard: every accepted beat must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && lif.log_valid && lif.log_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_beat: got bin=%0d code=%h, required no output", lif.log_bin, lif.log_out);
      end else begin
        e = sb.pop_front();
        if ({lif.log_out, lif.log_bin, lif.log_last} !== {e.code, e.bin, e.last})
          $display("FAIL beat: got code=%h bin=%0d last=%b, required code=%h bin=%0d last=%b",
                   lif.log_out, lif.log_bin, lif.log_last, e.code, e.bin, e.last);
        else n_pass++;
      end
    end
  end

  task automatic start_frame(input bins_t b);
    @(posedge clk); #1;
    mag_in = b; mag_valid = 1'b1;
    @(posedge clk); #1;
    mag_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({lif.log_valid, lif.log_last, lif.log_out, lif.log_bin, overrun, neg_seen} !== '0)
      $display("FAIL reset_outputs: got valid=%b out=%h bin=%0d ovr=%b neg=%b, required all 0",
               lif.log_valid, lif.log_out, lif.log_bin, overrun, neg_seen);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_drain: got %0d beats pending, required 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic wait_bin(input int bin, input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (lif.log_valid && lif.log_bin == 4'(bin)) break;
    end
    if (k == 100) begin
      n_checks++;
      $display("FAIL %s_wait_bin%0d: got timeout, required bin %0d valid", name, bin, bin);
    end
  endtask

  task automatic test_basic();
    logic [7:0] codes [NF] = '{8'h50, 8'h54, 8'h00, 8'h00, 8'h0C, 8'h87, 8'h08, 8'h10, 8'h18, 8'h20};
    bins_t b;
    b[0] = 18'd1024; b[1] = 18'd1536; b[2] = 18'd0; b[3] = 18'd1; b[4] = 18'd3;
    b[5] = 18'd131071; b[6] = 18'd2; b[7] = 18'd4; b[8] = 18'd8; b[9] = 18'd16;
    for (int i = 0; i < NF; i++) sb.push_back('{codes[i], 4'(i), (i == NF-1)});
    start_frame(b);
    n_checks++;
    if (lif.log_valid !== 1'b0) $display("FAIL latency_early: got valid=%b one cycle after strobe, required 0", lif.log_valid);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({lif.log_valid, lif.log_bin} !== {1'b1, 4'd0})
      $display("FAIL latency_first: got valid=%b bin=%0d two cycles after strobe, required 1/0", lif.log_valid, lif.log_bin);
    else n_pass++;
    drain("basic");
  endtask

  task automatic test_negative();
    bins_t b;
    for (int i = 0; i < NF; i++) b[i] = 18'd1024;
    b[0] = -18'sd5;
    push_model(b);
    start_frame(b);
    drain("neg");
    n_checks++;
    if (neg_seen !== 1'b1) $display("FAIL neg_seen_set: got %b, required 1", neg_seen);
    else n_pass++;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    n_checks++;
    if (neg_seen !== 1'b0) $display("FAIL neg_seen_clr: got %b, required 0", neg_seen);
    else n_pass++;
  endtask

  task automatic test_stall();
    bins_t b = rand_bins();
    logic [12:0] held;
    push_model(b);
    start_frame(b);
    wait_bin(3, "stall");
    lif.log_ready = 1'b0;
    held = {lif.log_out, lif.log_bin, lif.log_valid};
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({lif.log_out, lif.log_bin, lif.log_valid} !== held)
        $display("FAIL stall_hold%0d: got %h, required %h", c, {lif.log_out, lif.log_bin, lif.log_valid}, held);
      else n_pass++;
    end
    lif.log_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_overrun();
    bins_t b = rand_bins();
    bins_t b2;
    for (int i = 0; i < NF; i++) b2[i] = 18'd5;
    push_model(b);
    start_frame(b);
    wait_bin(4, "ovr");
    mag_in = b2; mag_valid = 1'b1;
    @(posedge clk); #1 mag_valid = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, required 1", overrun);
    else n_pass++;
    drain("ovr");
    repeat (20) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    bins_t b = rand_bins();
    bins_t b2 = rand_bins();
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_clr: got %b, required 0", overrun);
    else n_pass++;
    push_model(b);
    start_frame(b);
    wait_bin(9, "b2b");
    push_model(b2);
    mag_in = b2; mag_valid = 1'b1;
    @(posedge clk); #1 mag_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({lif.log_valid, lif.log_bin} !== {1'b1, 4'd0})
      $display("FAIL b2b_first: got valid=%b bin=%0d, required 1/0", lif.log_valid, lif.log_bin);
    else n_pass++;
    drain("b2b");
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b, required 0", overrun);
    else n_pass++;
  endtask

  task automatic test_clr_priority();
    bins_t b = rand_bins();
    b[0] = -18'sd100;
    push_model(b);
    start_frame(b);
    mag_valid = 1'b1; ovf_clr = 1'b1;
    @(posedge clk); #1;
    mag_valid = 1'b0; ovf_clr = 1'b0;
    n_checks++;
    if ({overrun, neg_seen} !== 2'b11)
      $display("FAIL clr_priority: got ovr=%b neg=%b, required 1/1", overrun, neg_seen);
    else n_pass++;
    drain("prio");
  endtask

  task automatic test_async_reset();
    bins_t b = rand_bins();
    push_model(b);
    start_frame(b);
    wait_bin(6, "rst");
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lif.log_valid, lif.log_last, lif.log_out, lif.log_bin, overrun, neg_seen} !== '0)
      $display("FAIL async_reset: got valid=%b out=%h bin=%0d ovr=%b neg=%b, required all 0",
               lif.log_valid, lif.log_out, lif.log_bin, overrun, neg_seen);
    else n_pass++;
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    b = rand_bins();
    push_model(b);
    start_frame(b);
    drain("rst");
  endtask

  initial begin
    lif.log_ready = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_clr_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
